// File: rtl/common_clock_fifo_core.sv
// common_clock_fifo_core: dual-port RAM plus wrap-bit pointers with full/empty/count status.
module common_clock_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  CLK,
    input  logic                  ARST_N,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  WR_ACK,
    output logic                  OVERFLOW,
    input  logic                  RAM_RE,
    output logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic                  FIFO_EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic                  UNDERFLOW,
    output logic [ADDR_WIDTH:0]   DATA_COUNT
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE  = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr, rptr;
    logic                  wr_acc, rd_acc;

    // Status depends only on the pointer registers, so inputs never glitch the flags.
    assign FIFO_EMPTY   = (wptr == rptr);
    assign FULL         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) & (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign DATA_COUNT   = wptr - rptr;
    assign ALMOST_FULL  = (DATA_COUNT >= AF);
    assign ALMOST_EMPTY = (DATA_COUNT <= AE);
    assign wr_acc       = WR_EN & ~FULL;
    assign rd_acc       = RAM_RE & ~FIFO_EMPTY;

    always_ff @(posedge CLK)
        if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= DIN;

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            wptr      <= '0;
            rptr      <= '0;
            RAM_DOUT  <= '0;
            WR_ACK    <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + ONE;
            if (rd_acc) begin
                rptr     <= rptr + ONE;
                RAM_DOUT <= mem[rptr[ADDR_WIDTH-1:0]];
            end
            WR_ACK    <= wr_acc;
            OVERFLOW  <= WR_EN & FULL;
            UNDERFLOW <= RAM_RE & FIFO_EMPTY;
        end
    end
endmodule
